// File: rtl/fletcher_pkg.sv
// Shared types for the Fletcher engine arbiter: FSM states, response layout, pointer helper.
// FLETCHER_ARB_GAP_CHECK_EN adds the DRAIN state used to abort packets that contain a gap.
package fletcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENG_RST  = 3'd1,
        ST_ENG_WARM = 3'd2,
        ST_STREAM   = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_RESP     = 3'd5
`ifdef FLETCHER_ARB_GAP_CHECK_EN
        ,
        ST_DRAIN    = 3'd6
`endif
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_CHECKSUM_WIDTH = 32;
    localparam int DEF_ID_WIDTH       = $clog2(DEF_NUM_REQ);

    // Response layout at the default configuration; the arbiter sizes its own copy from parameters.
    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]       id;
        logic [DEF_CHECKSUM_WIDTH-1:0] sum;
        logic [DEF_CHECKSUM_WIDTH-1:0] bytes;
        logic                          err;
    } rsp_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fletcher_rr_pick.sv
// Round-robin picker: rotate requests so ptr lands at bit 0, take the lowest set bit,
// and rotate the winning offset back into an absolute requester index.
module fletcher_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IW'((i + int'(ptr)) % N)];
        end
        // Descending scan so the lowest rotated position (closest to ptr) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
        gnt_idx = IW'((int'(off) + int'(ptr)) % N);
        any     = |req;
    end

endmodule

// File: rtl/fletcher_arbiter.sv
// Shares one Fletcher checksum engine among NUM_REQ requesters, round-robin, one packet at a time.
// Define FLETCHER_ARB_GAP_CHECK_EN to abort (drain + rsp_err_o) packets with a valid gap.
//
// Handshakes: a word moves on a cycle where req_valid_i[k] and req_ready_o[k] are both high;
// a response moves where rsp_valid_o and rsp_ready_i are both high, and rsp_* stay stable until then.
module fletcher_arbiter
    import fletcher_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int CHECKSUM_WIDTH = 32,
    parameter int DATA_WIDTH     = CHECKSUM_WIDTH / 2,
    parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [CHECKSUM_WIDTH-1:0]     rsp_sum_o,
    output logic [CHECKSUM_WIDTH-1:0]     rsp_bytes_o,
    output logic                          rsp_err_o,
    output logic                          eng_reset_o,
    output logic                          eng_done_o,
    output logic [DATA_WIDTH-1:0]         eng_data_o,
    input  logic [CHECKSUM_WIDTH-1:0]     eng_sum_i,
    input  logic [CHECKSUM_WIDTH-1:0]     eng_bytes_i,
    output arb_state_t                    dbg_state_o
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]       id;
        logic [CHECKSUM_WIDTH-1:0] sum;
        logic [CHECKSUM_WIDTH-1:0] bytes;
`ifdef FLETCHER_ARB_GAP_CHECK_EN
        logic                      err;
`endif
    } rsp_reg_t;

    arb_state_t          state;
    logic [ID_WIDTH-1:0] gnt;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_any;
    rsp_reg_t            rsp_q;
    logic                rsp_valid_q;

    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_valid;
    logic                  gnt_last;
    logic                  streaming;

    fletcher_rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_pick (
        .req     (req_valid_i),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        gnt_data  = req_data_i[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        gnt_valid = req_valid_i[gnt];
        gnt_last  = req_last_i[gnt];
`ifdef FLETCHER_ARB_GAP_CHECK_EN
        streaming = (state == ST_STREAM) || (state == ST_DRAIN);
`else
        streaming = (state == ST_STREAM);
`endif
        req_ready_o = '0;
        if (streaming) begin
            req_ready_o[gnt] = 1'b1;
        end
        // The engine has no enable, so gap cycles must present zero rather than stale data.
        eng_data_o = '0;
        if (state == ST_STREAM && gnt_valid) begin
            eng_data_o = gnt_data;
        end
        eng_done_o  = ((state == ST_STREAM) && gnt_valid && gnt_last) || (state == ST_CAPTURE);
        eng_reset_o = reset_i || (state == ST_ENG_RST);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            ptr         <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt   <= pick_idx;
                        state <= ST_ENG_RST;
                    end
                end
                ST_ENG_RST:  state <= ST_ENG_WARM;
                ST_ENG_WARM: state <= ST_STREAM;
                ST_STREAM: begin
`ifdef FLETCHER_ARB_GAP_CHECK_EN
                    if (!gnt_valid) begin
                        state <= ST_DRAIN;
                    end else if (gnt_last) begin
                        state <= ST_CAPTURE;
                    end
`else
                    if (gnt_valid && gnt_last) begin
                        state <= ST_CAPTURE;
                    end
`endif
                end
`ifdef FLETCHER_ARB_GAP_CHECK_EN
                ST_DRAIN: begin
                    if (gnt_valid && gnt_last) begin
                        rsp_q.id    <= gnt;
                        rsp_q.sum   <= '0;
                        rsp_q.bytes <= '0;
                        rsp_q.err   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
`endif
                ST_CAPTURE: begin
                    rsp_q.id    <= gnt;
                    rsp_q.sum   <= eng_sum_i;
                    rsp_q.bytes <= eng_bytes_i;
`ifdef FLETCHER_ARB_GAP_CHECK_EN
                    rsp_q.err   <= 1'b0;
`endif
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        ptr         <= ID_WIDTH'(rr_next(int'(gnt), NUM_REQ));
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_q.id;
    assign rsp_sum_o   = rsp_q.sum;
    assign rsp_bytes_o = rsp_q.bytes;
`ifdef FLETCHER_ARB_GAP_CHECK_EN
    assign rsp_err_o   = rsp_q.err;
`else
    assign rsp_err_o   = 1'b0;
`endif
    assign dbg_state_o = state;

endmodule

// File: tb/tb_fletcher_arbiter.sv
// Directed bench for fletcher_arbiter at CHECKSUM_WIDTH=16 with a reference Fletcher-16 engine.
// Optional FLETCHER_ARB_GAP_CHECK_EN scenario runs only when the macro is defined.
module tb_fletcher_arbiter;
    import fletcher_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int CW      = 16;
    localparam int DW      = 8;
    localparam int IW      = 2;
    localparam int EW      = 1 + IW + CW;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*DW-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]    req_last  = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IW-1:0]         rsp_id;
    logic [CW-1:0]         rsp_sum;
    logic [CW-1:0]         rsp_bytes;
    logic                  rsp_err;
    logic                  eng_reset;
    logic                  eng_done;
    logic [DW-1:0]         eng_data;
    logic [CW-1:0]         eng_sum;
    logic [CW-1:0]         eng_bytes;
    arb_state_t            dbg_state;

    fletcher_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .CHECKSUM_WIDTH (CW)
    ) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_bytes_o (rsp_bytes),
        .rsp_err_o   (rsp_err),
        .eng_reset_o (eng_reset),
        .eng_done_o  (eng_done),
        .eng_data_o  (eng_data),
        .eng_sum_i   (eng_sum),
        .eng_bytes_i (eng_bytes),
        .dbg_state_o (dbg_state)
    );

    // ---------------- reference Fletcher-16 engine ----------------
    function automatic logic [7:0] add255(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b};
        return (t >= 9'd255) ? 8'(t - 9'd255) : t[7:0];
    endfunction

    function automatic logic [15:0] chk_bytes(input logic [15:0] sum);
        logic [7:0] c0, c1;
        c0 = 8'd255 - add255(sum[7:0], sum[15:8]);
        c1 = 8'd255 - add255(sum[7:0], c0);
        return {c0, c1};
    endfunction

    logic [7:0] e_s1, e_s2;
    logic       e_warm, e_held;
    always @(posedge clock) begin
        if (eng_reset) begin
            e_s1 <= 8'd0; e_s2 <= 8'd0; e_warm <= 1'b1; e_held <= 1'b0;
        end else if (e_warm) begin
            e_warm <= 1'b0;
        end else if (!e_held) begin
            e_s1   <= add255(e_s1, eng_data);
            e_s2   <= add255(e_s2, add255(e_s1, eng_data));
            e_held <= eng_done;
        end else begin
            e_held <= eng_done;
        end
    end
    assign eng_sum   = {e_s2, e_s1};
    assign eng_bytes = chk_bytes({e_s2, e_s1});

    // ---------------- driver: per-requester word sources ----------------
    logic [7:0] src_buf[NUM_REQ][16];
    int         src_len[NUM_REQ];
    int         src_pos[NUM_REQ];
    int         gap_at[NUM_REQ];
    int         last_cyc = -1;

    task automatic load(input int k, input string s);
        for (int i = 0; i < s.len(); i++) src_buf[k][i] = s[i];
        src_len[k] = s.len();
        src_pos[k] = 0;
    endtask

    task automatic load_byte(input int k, input logic [7:0] b);
        src_buf[k][0] = b;
        src_len[k]    = 1;
        src_pos[k]    = 0;
    endtask

    task automatic drive_sources();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (src_pos[k] == gap_at[k]) begin
                req_valid[k] = 1'b0;
                gap_at[k]    = -1;
            end else begin
                req_valid[k] = (src_pos[k] < src_len[k]);
            end
            req_data[k*DW +: DW] = (src_pos[k] < src_len[k]) ? src_buf[k][src_pos[k]] : 8'h00;
            req_last[k]          = (src_pos[k] == src_len[k] - 1);
        end
    endtask

    initial begin
        logic [NUM_REQ-1:0] hs;
        for (int k = 0; k < NUM_REQ; k++) begin
            src_len[k] = 0; src_pos[k] = 0; gap_at[k] = -1;
        end
        forever begin
            @(negedge clock);
            hs = req_valid & req_ready;
            if ((hs & req_last) != '0) last_cyc = cyc;
            @(posedge clock);
            #1;
            for (int k = 0; k < NUM_REQ; k++) if (hs[k]) src_pos[k]++;
            drive_sources();
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_rsp(input string tag, input int hold, output int t_valid);
        bit            ok;
        logic [EW-1:0] e;
        logic [15:0]   eb;
        ok      = 1'b0;
        t_valid = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, ".seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        t_valid = cyc;
        if (exp_q.size() == 0) begin
            check({tag, ".expq"}, 64'd0, 64'd1);
            return;
        end
        e  = exp_q.pop_front();
        eb = e[EW-1] ? 16'h0000 : chk_bytes(e[CW-1:0]);
        check({tag, ".id"},    64'(rsp_id),    64'(e[CW +: IW]));
        check({tag, ".sum"},   64'(rsp_sum),   64'(e[CW-1:0]));
        check({tag, ".bytes"}, 64'(rsp_bytes), 64'(eb));
        check({tag, ".err"},   64'(rsp_err),   64'(e[EW-1]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, ".hold"}, 64'({rsp_valid, rsp_id, rsp_sum, rsp_bytes, req_ready}),
                  64'({1'b1, e[CW +: IW], e[CW-1:0], eb, 4'b0000}));
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        @(negedge clock);
        check({tag, ".drop"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        req_valid = '0;
        req_last  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            src_len[k] = 0; src_pos[k] = 0; gap_at[k] = -1;
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        bit seen;

        // Reset values.
        repeat (3) @(negedge clock);
        check("rst.eng_reset", 64'(eng_reset), 64'd1);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst.ready", 64'(req_ready), 64'd0);
        check("rst.rsp", 64'({rsp_valid, rsp_id, rsp_sum, rsp_bytes, rsp_err}), 64'd0);
        check("rst.eng", 64'({eng_done, eng_data, eng_reset}), 64'd0);
        check("rst.state", 64'(dbg_state), 64'(ST_IDLE));

        // Requester 0, "abcde": response exactly two cycles after the last handshake.
        load(0, "abcde");
        exp_q.push_back({1'b0, 2'd0, 16'hC8F0});
        expect_rsp("abcde", 0, t);
        check("abcde.lat", 64'(t), 64'(last_cyc + 2));

        // ptr back to 0; 1 and 3 together -> 1 then 3.
        do_reset();
        load(1, "ab");
        load(3, "xyz");
        exp_q.push_back({1'b0, 2'd1, 16'h25C3});
        exp_q.push_back({1'b0, 2'd3, 16'hD66C});
        expect_rsp("rr.r1", 0, t);
        expect_rsp("rr.r3", 0, t);

        // ptr=0: lone request from 1 moves ptr to 2; then 1 and 2 together -> 2 first.
        load(1, "a");
        exp_q.push_back({1'b0, 2'd1, 16'h6161});
        expect_rsp("rr.solo1", 0, t);
        load(1, "b");
        load(2, "c");
        exp_q.push_back({1'b0, 2'd2, 16'h6363});
        exp_q.push_back({1'b0, 2'd1, 16'h6262});
        expect_rsp("rr.r2", 0, t);
        expect_rsp("rr.r1b", 0, t);

        // Requester 2 "abcdef" held 10 cycles while 0 waits; then single byte 0x01.
        load(2, "abcdef");
        load_byte(0, 8'h01);
        exp_q.push_back({1'b0, 2'd2, 16'h2057});
        exp_q.push_back({1'b0, 2'd0, 16'h0101});
        expect_rsp("hold", 10, t);
        expect_rsp("single", 0, t);

        // Asynchronous reset mid-STREAM.
        load(0, "abcde");
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst.stream", 64'(seen), 64'd1);
        @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        req_valid = '0;
        req_last  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            src_len[k] = 0; src_pos[k] = 0; gap_at[k] = -1;
        end
        #1;
        check("midrst.out", 64'({req_ready, rsp_valid, eng_done, eng_data, eng_reset}),
              64'({4'b0000, 1'b0, 1'b0, 8'h00, 1'b1}));
        check("midrst.state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clock);
        #1;
        reset = 1'b0;
        load(0, "abcde");
        exp_q.push_back({1'b0, 2'd0, 16'hC8F0});
        expect_rsp("postrst", 0, t);

`ifdef FLETCHER_ARB_GAP_CHECK_EN
        // One-cycle gap after byte 2: remainder drained, error response with zero sums.
        load(3, "abcde");
        gap_at[3] = 2;
        exp_q.push_back({1'b1, 2'd3, 16'h0000});
        expect_rsp("gap", 0, t);
        check("gap.drained", 64'(src_pos[3]), 64'd5);
`endif

        check("expq.empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
